// File: rtl/stream_demux_1x3_pkg.sv
//------------------------------------------------------------------------------
// stream_demux_1x3_pkg: FSM encoding, channel constants and sw_mode decode. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package stream_demux_1x3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;

  // Unlisted codes fall back to channel 0 so a glitchy switch never selects nothing.
  function automatic logic [1:0] decode_mode(input logic [3:0] mode);
    logic [1:0] ch;
    ch = CH0;
    case (mode)
      4'b0100, 4'b0101: ch = CH1;
      4'b1000, 4'b1001: ch = CH2;
      default:          ch = CH0;
    endcase
    return ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_1x3_sync_ff.sv
//------------------------------------------------------------------------------
// sync_ff: multi-stage flop synchronizer, async active-low reset. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/stream_demux_1x3.sv
//------------------------------------------------------------------------------
// stream_demux_1x3: 1-to-3 valid/ready demux steered by synchronized sw_mode.
// Optional ROUTER_STATS_EN adds per-channel beat counters on beat_cnt. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_demux_1x3
  import stream_demux_1x3_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            sw_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_valid,
  input  logic [2:0]            out_ready,
  output logic [1:0]            cur_ch
`ifdef ROUTER_STATS_EN
  ,
  output logic [23:0]           beat_cnt
`endif
);

  logic [3:0]            mode_sync;
  logic [1:0]            dec_ch;
  state_t                state;
  logic                  hold_valid;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  sel_ready;
  logic                  in_fire;
  logic                  out_fire;
  logic                  hold_free;

  sync_ff #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_mode),
    .q     (mode_sync)
  );

  assign dec_ch = decode_mode(mode_sync);

  always_comb begin
    sel_ready = 1'b0;
    case (cur_ch)
      CH0:     sel_ready = out_ready[0];
      CH1:     sel_ready = out_ready[1];
      CH2:     sel_ready = out_ready[2];
      default: sel_ready = 1'b0;
    endcase
  end

  // cur_ch only moves in IDLE with the holding register empty, so this stays one-hot-or-zero.
  always_comb begin
    out_valid = 3'b000;
    if (hold_valid) begin
      case (cur_ch)
        CH0:     out_valid = 3'b001;
        CH1:     out_valid = 3'b010;
        CH2:     out_valid = 3'b100;
        default: out_valid = 3'b000;
      endcase
    end
  end

  assign in_ready  = (state == ROUTE) && !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = hold_valid && sel_ready;
  assign hold_free = !hold_valid || out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_ch     <= CH0;
      hold_valid <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cur_ch <= dec_ch;
          state  <= ROUTE;
        end
        ROUTE: if (dec_ch != cur_ch) state <= DRAIN;
        DRAIN: if (!hold_valid) state <= IDLE;
        default: state <= IDLE;
      endcase

      // The skid always refills the holding register first, so hold empty implies skid empty.
      if (hold_free) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          hold_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else if (in_fire) begin
          out_data   <= in_data;
          hold_valid <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef ROUTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) beat_cnt[8*k +: 8] <= beat_cnt[8*k +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1x3.sv
//------------------------------------------------------------------------------
// tb_stream_demux_1x3: directed self-checking bench for stream_demux_1x3. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_demux_1x3;
  import stream_demux_1x3_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [1:0] cur_ch;
`ifdef ROUTER_STATS_EN
  logic [23:0] beat_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux_1x3 #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_mode   (sw_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_ch    (cur_ch)
`ifdef ROUTER_STATS_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a given state/channel; the checks afterwards flag a timeout.
  task automatic wait_for(input string tag, input state_t st, input logic [1:0] ch);
    for (int i = 0; i < 12; i++) begin
      if (dut.state == st && cur_ch == ch) break;
      tick();
    end
    check({tag, "_state"}, 32'(dut.state), 32'(st));
    check({tag, "_ch"}, 32'(cur_ch), 32'(ch));
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_mode   = 4'b0000;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 3'b000;
    tick();
    tick();

    // Reset values
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);

    rst_n = 1'b1;
    tick();
    check("first_route", 32'(dut.state), 32'(ROUTE));
    check("first_in_ready", 32'(in_ready), 32'd1);

    // Full-throughput stream on channel 1
    sw_mode   = 4'b0100;
    out_ready = 3'b111;
    wait_for("to_ch1", ROUTE, 2'd1);
    in_valid = 1'b1;
    in_data  = 8'h11;
    check("s1_rdy0", 32'(in_ready), 32'd1);
    tick();
    check("s1_v0", 32'(out_valid), 32'b010);
    check("s1_d0", 32'(out_data), 32'h11);
    check("s1_rdy1", 32'(in_ready), 32'd1);
    in_data = 8'h22;
    tick();
    check("s1_v1", 32'(out_valid), 32'b010);
    check("s1_d1", 32'(out_data), 32'h22);
    check("s1_rdy2", 32'(in_ready), 32'd1);
    in_data = 8'h33;
    tick();
    check("s1_v2", 32'(out_valid), 32'b010);
    check("s1_d2", 32'(out_data), 32'h33);
    check("s1_ch", 32'(cur_ch), 32'd1);
    in_valid = 1'b0;
    tick();
    check("s1_empty", 32'(out_valid), 32'd0);

    // Back-pressure on channel 2: skid fills, in_ready drops, data holds
    sw_mode = 4'b1000;
    wait_for("to_ch2", ROUTE, 2'd2);
    out_ready = 3'b011;
    in_valid  = 1'b1;
    in_data   = 8'hA0;
    check("bp_rdy0", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'hA1;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_rdy_drop", 32'(in_ready), 32'd0);
    check("bp_v", 32'(out_valid), 32'b100);
    check("bp_hold0", 32'(out_data), 32'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", 32'(out_data), 32'hA0);
      check("bp_rdy_low", 32'(in_ready), 32'd0);
    end
    out_ready = 3'b111;
    tick();
    check("bp_d1_v", 32'(out_valid), 32'b100);
    check("bp_d1", 32'(out_data), 32'hA1);
    check("bp_rdy_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Mode change while channel 0 is stalled: drain on ch0, then switch to ch2
    sw_mode = 4'b0000;
    wait_for("to_ch0", ROUTE, 2'd0);
    out_ready = 3'b110;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    tick();
    in_valid = 1'b0;
    sw_mode  = 4'b1001;
    wait_for("drain", DRAIN, 2'd0);
    check("drain_rdy", 32'(in_ready), 32'd0);
    check("drain_v", 32'(out_valid), 32'b001);
    check("drain_d", 32'(out_data), 32'h5A);
    out_ready = 3'b111;
    tick();
    check("drain_done", 32'(out_valid), 32'd0);
    wait_for("after_drain", ROUTE, 2'd2);
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    check("new_ch2_v", 32'(out_valid), 32'b100);
    check("new_ch2_d", 32'(out_data), 32'h77);
    tick();

    // Undefined codes map to channel 0
    sw_mode = 4'b1111;
    wait_for("code_1111", ROUTE, 2'd0);
    sw_mode = 4'b0101;
    wait_for("code_0101", ROUTE, 2'd1);
    sw_mode = 4'b0110;
    wait_for("code_0110", ROUTE, 2'd0);

    // Async reset with skid and holding both full
    sw_mode = 4'b0101;
    wait_for("pre_rst", ROUTE, 2'd1);
    out_ready = 3'b000;
    in_valid  = 1'b1;
    in_data   = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_valid = 1'b0;
    check("full_rdy", 32'(in_ready), 32'd0);
    check("full_v", 32'(out_valid), 32'b010);
    rst_n = 1'b0;
    #1;
    check("arst_v", 32'(out_valid), 32'd0);
    check("arst_d", 32'(out_data), 32'd0);
    check("arst_rdy", 32'(in_ready), 32'd0);
    check("arst_ch", 32'(cur_ch), 32'd0);
    check("arst_state", 32'(dut.state), 32'(IDLE));
    tick();
    rst_n     = 1'b1;
    out_ready = 3'b111;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no_stale", 32'(out_valid), 32'd0);
    end

`ifdef ROUTER_STATS_EN
    wait_for("stats_ch1", ROUTE, 2'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("beat_cnt", 32'(beat_cnt), 32'h000400);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux_1x3.md
STREAM_DEMUX_1X3 -- requirements
Module: stream_demux_1x3

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of sw_mode synchronizer flops (legal values 2..3).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port sw_mode, input, 4 bits: raw, asynchronous mode switches.
REQ-006 The block SHALL have ports in_data (input, DATA_WIDTH), in_valid (input, 1) and in_ready (output, 1) forming the upstream valid/ready stream.
REQ-007 The block SHALL have ports out_data (output, DATA_WIDTH, shared) plus per-channel out_valid[2:0] (output, 3) and out_ready[2:0] (input, 3) forming three downstream streams.
REQ-008 The block SHALL have port cur_ch, output, 2 bits: the committed channel index 0..2.

Function
REQ-009 sw_mode SHALL pass through SYNC_STAGES flops before decode.
REQ-010 Decode SHALL map 0000–0011 to channel 0, 0100–0101 to channel 1, 1000–1001 to channel 2, and every other code to channel 0.
REQ-011 The FSM SHALL have three states: IDLE, ROUTE and DRAIN.
REQ-012 IDLE SHALL commit the decoded channel to cur_ch and go to ROUTE on the next cycle.
REQ-013 ROUTE SHALL go to DRAIN when the decoded channel differs from cur_ch.
REQ-014 DRAIN SHALL deassert in_ready and return to IDLE once the output holding register is empty.
REQ-015 Only one channel SHALL ever be active: out_valid[k] may be 1 only for k == cur_ch.
REQ-016 A single-entry output holding register SHALL sit behind a single-entry skid register.
REQ-017 In ROUTE, in_ready SHALL be 1 when the skid register is empty; an accepted beat appears on out_data/out_valid no earlier than the next cycle (latency 1).
REQ-018 When the holding register is full and out_ready[cur_ch]=0, an accepted beat SHALL be captured in the skid register and in_ready SHALL drop on the following cycle.
REQ-019 Full throughput SHALL be supported: one beat per cycle while out_ready[cur_ch]=1.
REQ-020 out_data SHALL stay stable while out_valid[cur_ch]=1 and out_ready[cur_ch]=0; beats SHALL never be dropped, duplicated or reordered.
REQ-021 A mode change SHALL never split a beat: every beat accepted before DRAIN is delivered on the old channel.
REQ-022 A mode change back to the old channel during DRAIN SHALL still complete the drain and pass through IDLE.
REQ-023 in_ready SHALL be 0 in IDLE and DRAIN.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously clear state to IDLE, cur_ch to 0, out_valid to 000, out_data to 0, in_ready to 0, the skid and holding registers to empty, and the synchronizer flops to 0.
REQ-025 An assertion of rst_n mid-transfer SHALL discard buffered beats.
REQ-026 Release of rst_n SHALL take effect on the next clk edge; the first IDLE→ROUTE transition follows within 2 cycles.

Configuration
REQ-027 With ROUTER_STATS_EN defined, the block SHALL add output beat_cnt[23:0], three 8-bit wrap-around counters (channel k in bits 8k+7:8k) that increment on each out_valid[k]&&out_ready[k], cleared by reset.
REQ-028 Without ROUTER_STATS_EN, beat_cnt SHALL be absent and no counter logic is generated.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ROUTE=2'd1, DRAIN=2'd2), the channel constants CH0..CH2, and the sw_mode decode function.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_ff, parameterized by width and stage count; all other logic is flat in stream_demux_1x3.

Verification
REQ-031 Bench SHALL cover: reset, sw_mode=0100, stream 0x11,0x22,0x33 with out_ready=111 -> out_valid[1] only, data in order, cur_ch=1, one beat per cycle.
REQ-032 Bench SHALL cover: sw_mode=1000, out_ready[2]=0 for 5 cycles while 0xA0,0xA1 are offered -> in_ready drops after the second beat, out_data holds 0xA0, then both delivered in order after release.
REQ-033 Bench SHALL cover: mode 0000→1001 while channel 0 holds 0x5A and out_ready[0]=0 -> state DRAIN, in_ready=0, 0x5A delivered on ch0 after release, then cur_ch=2 and new beats go to ch2.
REQ-034 Bench SHALL cover: sw_mode=1111 -> cur_ch=0; sw_mode=0110 -> cur_ch=0.
REQ-035 Bench SHALL cover: rst_n pulsed low with skid and holding both full -> all outputs reset immediately, no stale beat after release.
REQ-036 Bench SHALL cover: with ROUTER_STATS_EN, 260 beats on ch1 -> beat_cnt[15:8]=4 (wrap) and the other fields 0.
